// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite codes, slave FSM states and byte-lane helper
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_e;

    // Little-endian lane enables for a legal size/offset pair.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            3'd0:    byte_en = 4'b0001 << lane;
            3'd1:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - word-wide SRAM, async read, sync byte-enabled write
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB-Lite SRAM slave with wait states and two-cycle ERROR
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    slave_state_e          r_state, w_next_state;
    logic [3:0]            r_wait_cnt, w_wait_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [3:0]            r_be;
    logic                  w_ready, w_accept, w_illegal, w_mem_we;
    logic [31:0]           w_mem_rdata;
    logic                  w_unused_ok;

    assign w_unused_ok = &{1'b0, HBURST, HPROT, HTRANS[0]};

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_accept = w_ready & HSEL & HREADY & HTRANS[1];

    assign w_illegal = (HSIZE > HSIZE_WORD)
                    || ((HSIZE == HSIZE_HALF) && HADDR[0])
                    || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
                    || (|HADDR[31:ADDR_WIDTH+2]);

    always_comb begin
        w_next_state    = ST_IDLE;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state    = ST_WAIT;
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            ST_ERR1: w_next_state = ST_ERR2;
            // IDLE, DATA and ERR2 all accept a new address phase identically.
            default: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_next_state = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_next_state    = ST_WAIT;
                        w_wait_cnt_next = WAIT_INIT;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_be       <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_accept) begin
                r_addr  <= HADDR[ADDR_WIDTH+1:2];
                r_write <= HWRITE;
                r_be    <= byte_en(HSIZE, HADDR[1:0]);
            end
        end
    end

    // Reset at the closing edge of a write data phase also drops the commit.
    assign w_mem_we = HRESETn && (r_state == ST_DATA) && r_write;

    ahb_slave_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .i_clk   (HCLK),
        .i_we    (w_mem_we),
        .i_be    (r_be),
        .i_addr  (r_addr),
        .i_wdata (HWDATA),
        .o_rdata (w_mem_rdata)
    );

    assign HREADYOUT = w_ready;
    assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = ((r_state == ST_DATA) && !r_write) ? w_mem_rdata : 32'd0;

endmodule
